// File: rtl/bcd_pkg.sv
// Shared BCD constants and converter state encoding, also used by the BCD counter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0]  BCD_ADJ_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 from a nibble that is 8 or above.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_c_o
);

    assign digit_c_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i - BCD_ADJ_VAL) : digit_i;

endmodule : bcd_digit_adj

// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to binary converter, one shift-and-adjust step per cycle, valid/ready on both sides.
// Optional invalid-digit reporting is enabled with `define BCD_TO_BIN_DIGIT_CHECK_EN.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [BCD_DIGIT_W*DIGITS-1:0]   in_bcd_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [BIN_W-1:0]                out_bin_o,
    output logic                            out_err_o,
    output logic                            busy_o
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    bcd_state_e         state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   out_bin_q, out_bin_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [SR_W-1:0]    shift_c;
    logic [BCD_W-1:0]   adj_c;
    logic [SR_W-1:0]    step_c;

    // One iteration: shift the whole {bcd, bin} register right, then fix up each digit.
    assign shift_c = {1'b0, sr_q[SR_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i   (shift_c[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_c_o (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign step_c = {adj_c, shift_c[BIN_W-1:0]};

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic out_err_q, out_err_d;
    logic err_in_c;

    always_comb begin
        err_in_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (in_bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                err_in_c = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_bin_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
            err_q       <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_bin_q   <= out_bin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
            err_q       <= err_d;
            out_err_q   <= out_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        out_bin_d = out_bin_q;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        err_d     = err_q;
        out_err_d = out_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    state_d = SHIFT;
                    sr_d    = {in_bcd_i, {BIN_W{1'b0}}};
                    cnt_d   = '0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                    err_d     = err_in_c;
                    out_err_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                sr_d  = step_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d   = DONE;
                    out_bin_d = step_c[BIN_W-1:0];
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                    if (err_q) begin
                        out_bin_d = '0;
                        out_err_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next state's decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_bin_o   = out_bin_q;
    assign busy_o      = busy_q;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    assign out_err_o   = out_err_q;
`else
    assign out_err_o   = 1'b0;
`endif

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against a decimal arithmetic reference.
module tb_bcd_to_bin_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_bcd;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_bin;
    logic       out_err;
    logic       busy;

    int checks;
    int errors;
    int sent;
    int received;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_bcd_i    (in_bcd),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_bin_o   (out_bin),
        .out_err_o   (out_err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_value(input logic [7:0] bcd);
        return int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    endfunction

    function automatic bit ref_invalid(input logic [7:0] bcd);
        return (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles out_ready stays low once the result appears.
    task automatic convert(input logic [7:0] bcd, input int hold);
        int  waited;
        int  lat;
        int  exp_bin;
        bit  exp_err;
        bit  check_bin;
        bit  bad;
        bad     = ref_invalid(bcd);
        exp_bin = ref_value(bcd);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        exp_err   = bad;
        check_bin = 1'b1;
        if (bad) exp_bin = 0;
`else
        exp_err   = 1'b0;
        check_bin = !bad;
`endif
        out_ready = (hold == 0);
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bcd   = bcd;
        tick();
        sent++;
        in_valid = 1'b0;
        in_bcd   = 8'($urandom);
        chk("busy_in_shift", 32'(busy), 32'd1);
        chk("in_ready_in_shift", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd7);
        if (check_bin) chk("out_bin", 32'(out_bin), 32'(exp_bin));
        chk("out_err", 32'(out_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            if (check_bin) chk("hold_out_bin", 32'(out_bin), 32'(exp_bin));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        received++;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        if (check_bin) chk("post_out_bin_held", 32'(out_bin), 32'(exp_bin));
    endtask

    initial begin
        logic [7:0] w;
        checks    = 0;
        errors    = 0;
        sent      = 0;
        received  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = 8'h00;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_bin", 32'(out_bin), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);

        convert(8'h99, 0);
        convert(8'h00, 0);
        convert(8'h42, 0);
        convert(8'h10, 0);
        convert(8'h57, 5);

        // Reset pulse lands on the third SHIFT iteration of 8'h88.
        in_valid = 1'b1;
        in_bcd   = 8'h88;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_bin", 32'(out_bin), 32'd0);
        convert(8'h21, 0);

        convert(8'h3A, 0);
        convert(8'h05, 0);

        // Random valid words with random backpressure.
        for (int i = 0; i < 30; i++) begin
            w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert(w, int'($urandom_range(0, 3)));
        end

        // BCD counter sweep 00..99 back to back.
        for (int n = 0; n < 100; n++) begin
            w = {4'(n / 10), 4'(n % 10)};
            convert(w, 0);
        end

        chk("words_sent_vs_received", 32'(received), 32'(sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bcd_to_bin_seq
